word_serializer: RTL and testbench
==================================

// Module: word_serializer
// PURPOSE
//  Parametrised successor to the fixed 64->2x32 word split: accepts one IN_W-bit word
//  over valid/ready and emits it as BEATS = IN_W/OUT_W narrower beats over valid/ready.
//  Beat order is selectable per word. Sits between wide datapath results and narrow
//  32-bit consumers (bus/UART/display paths). Includes abort and completed-word count.
// PARAMETERS
//  IN_W    64  input word width; must be an integer multiple of OUT_W
//  OUT_W   32  output beat width; BEATS = IN_W/OUT_W must be >= 2 (else elaboration error)
//  CNT_W   8   width of words_done counter
// PORTS
//  clk        in   1      single clock, all logic rising-edge
//  rst_n      in   1      asynchronous active-low reset
//  in_data    in   IN_W   word to serialise
//  in_msb     in   1      order for this word: 0 = low slice first, 1 = high slice first
//  in_valid   in   1      in_data/in_msb valid
//  in_ready   out  1      block can accept a word this cycle
//  out_data   out  OUT_W  current beat
//  out_valid  out  1      out_data valid
//  out_ready  in   1      consumer accepts beat
//  out_last   out  1      current beat is final beat of word
//  out_idx    out  clog2(BEATS)  slice index of current beat (0 = bits[OUT_W-1:0])
//  abort      in   1      synchronous: drop current word
//  busy       out  1      word held (state SEND)
//  words_done out  CNT_W  count of words whose last beat transferred; wraps
// BEHAVIOUR
//  Reset (rst_n low, async): state IDLE, beat cnt 0, held word 0, order 0, out_data 0,
//   out_valid 0, out_last 0, out_idx 0, busy 0, words_done 0; in_ready forced 0 while rst_n low.
//   Reset mid-word discards it; no further beats.
//  States: IDLE, SEND. out_valid = busy = (state==SEND).
//  Accept: in_fire = in_valid & in_ready. in_ready = !abort & (IDLE | (SEND & out_last & out_ready)).
//   (in_ready is combinational on out_ready and abort.)
//  IDLE: on in_fire latch in_data, in_msb; cnt<=0; ->SEND. First beat valid next cycle
//   (latency 1 cycle input->first beat).
//  SEND: out_idx = in_msb_q ? BEATS-1-cnt : cnt; out_data = held[out_idx*OUT_W +: OUT_W];
//   out_last = (cnt==BEATS-1). out_data/out_idx/out_last stable while out_valid & !out_ready.
//  Beat transfer (out_valid & out_ready), not last: cnt<=cnt+1.
//  Last-beat transfer: words_done<=words_done+1 (wraps 2^CNT_W-1 -> 0); if in_fire same
//   cycle load new word, cnt<=0, stay SEND (no bubble); else ->IDLE.
//  Throughput: one word per BEATS cycles with out_ready held high.
//  abort=1: highest priority; next cycle state IDLE, cnt 0, out_valid 0; no in_fire that
//   cycle; words_done unchanged even if last beat transferred that cycle (the beat is
//   delivered but not counted). abort in IDLE has no effect.
//  in_valid ignored while in_ready=0; upstream holds its word.
// TESTING (IN_W=64, OUT_W=32 unless stated)
//  1 in_data=0x1122334455667788, in_msb=0, out_ready=1 -> beats 0x55667788 (idx0),
//    0x11223344 (idx1, last); words_done=1; IDLE after.
//  2 same word, in_msb=1 -> 0x11223344 (idx1) then 0x55667788 (idx0, last).
//  3 out_ready low 3 cycles on beat 0 -> out_data=0x55667788 held stable, in_ready=0,
//    beat 1 only after out_ready rises.
//  4 in_valid held, two words, out_ready=1 -> 4 beats in 4 consecutive cycles, in_ready
//    high on each last beat, words_done=2; CNT_W=2 with 5 words -> words_done=1 (wrap).
//  5 abort after beat 0 transfers -> out_valid 0 next cycle, no beat 1, words_done unchanged;
//    following word serialises normally. Also IN_W=96,OUT_W=32: 3 beats, idx 0,1,2.
//  6 rst_n low during beat 1 -> out_valid/out_data/words_done 0 immediately, in_ready 0;
//    after release in_ready 1, IDLE.

Source files
------------

// File: rtl/word_serializer_if.sv
// Handshake bundle for word_serializer: wide word in, narrow beats out.
// master = upstream/downstream side (bench or surrounding logic), slave = serializer.
interface word_serializer_if #(
  parameter int unsigned IN_W  = 64,
  parameter int unsigned OUT_W = 32
);
  localparam int unsigned BEATS = IN_W / OUT_W;
  localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [IN_W-1:0]  in_data;
  logic             in_msb;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [IDX_W-1:0] out_idx;

  modport master (
    output in_data, in_msb, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_idx
  );

  modport slave (
    input  in_data, in_msb, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, out_idx
  );
endinterface

// File: rtl/word_serializer.sv
// Splits one IN_W-bit word into BEATS = IN_W/OUT_W beats, low or high slice first per word.
// Back-to-back words stream without a bubble; abort drops the held word; words_done counts
// words whose last beat was transferred.
module word_serializer #(
  parameter int unsigned IN_W  = 64,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  word_serializer_if.slave    bus,
  input  logic                abort,
  output logic                busy,
  output logic [CNT_W-1:0]    words_done
);
  localparam int unsigned BEATS = IN_W / OUT_W;
  localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  if (BEATS < 2 || IN_W != BEATS * OUT_W) begin : g_bad_params
    $error("word_serializer: IN_W must be a multiple of OUT_W with at least 2 beats");
  end

  typedef enum logic {StIdle, StSend} state_t;

  state_t                       state_q;
  logic [IDX_W-1:0]             cnt_q;
  logic                         msb_q;
  logic [BEATS-1:0][OUT_W-1:0]  held_q;   // held word viewed as an array of beats

  logic             in_fire;
  logic             last;
  logic [IDX_W-1:0] idx;

  assign busy          = (state_q == StSend);
  assign last          = busy && (cnt_q == LAST_IDX);
  assign idx           = msb_q ? (LAST_IDX - cnt_q) : cnt_q;

  assign bus.out_valid = busy;
  assign bus.out_last  = last;
  assign bus.out_idx   = idx;
  assign bus.out_data  = held_q[idx];

  // Ready in idle, or on a last beat being taken so the next word follows with no bubble.
  assign bus.in_ready  = rst_n && !abort && ((state_q == StIdle) || (last && bus.out_ready));
  assign in_fire       = bus.in_valid && bus.in_ready;

  // FSM, beat counter, held word and completed-word counter; abort overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      msb_q      <= 1'b0;
      held_q     <= '0;
      words_done <= '0;
    end else if (abort) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_fire) begin
            held_q  <= bus.in_data;
            msb_q   <= bus.in_msb;
            cnt_q   <= '0;
            state_q <= StSend;
          end
        end
        StSend: begin
          if (bus.out_ready) begin
            if (last) begin
              words_done <= words_done + CNT_W'(1);
              cnt_q      <= '0;
              if (in_fire) begin
                held_q <= bus.in_data;
                msb_q  <= bus.in_msb;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              cnt_q <= cnt_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: a 64->32 instance (2-bit word counter to exercise wrap)
// and a 96->32 instance for the three-beat case.
module tb_word_serializer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       abort_a = 1'b0;
  logic       abort_b = 1'b0;
  logic       busy_a, busy_b;
  logic [1:0] wd_a;
  logic [7:0] wd_b;

  word_serializer_if #(.IN_W(64), .OUT_W(32)) bus_a ();
  word_serializer_if #(.IN_W(96), .OUT_W(32)) bus_b ();

  word_serializer #(.IN_W(64), .OUT_W(32), .CNT_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .abort(abort_a), .busy(busy_a),
    .words_done(wd_a)
  );

  word_serializer #(.IN_W(96), .OUT_W(32), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .abort(abort_b), .busy(busy_b),
    .words_done(wd_b)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [1:0] wd_exp = 2'd0;

  typedef struct {
    logic [63:0] word;
    logic        msb;
    logic [31:0] b0;
    logic        i0;
    logic [31:0] b1;
    logic        i1;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full word on dut_a with out_ready high, checking every beat.
  task automatic run_word(input vec_t v);
    @(negedge clk);
    bus_a.in_data = v.word; bus_a.in_msb = v.msb; bus_a.in_valid = 1'b1; bus_a.out_ready = 1'b1;
    #1 check("idle_in_ready", 64'(bus_a.in_ready), 64'(1));
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    #1;
    check("beat0_valid", 64'(bus_a.out_valid), 64'(1));
    check("beat0_data", 64'(bus_a.out_data), 64'(v.b0));
    check("beat0_idx", 64'(bus_a.out_idx), 64'(v.i0));
    check("beat0_last", 64'(bus_a.out_last), 64'(0));
    @(negedge clk);
    #1;
    check("beat1_data", 64'(bus_a.out_data), 64'(v.b1));
    check("beat1_idx", 64'(bus_a.out_idx), 64'(v.i1));
    check("beat1_last", 64'(bus_a.out_last), 64'(1));
    check("beat1_in_ready", 64'(bus_a.in_ready), 64'(1));
    wd_exp++;
    @(negedge clk);
    #1;
    check("after_busy", 64'(busy_a), 64'(0));
    check("after_valid", 64'(bus_a.out_valid), 64'(0));
    check("words_done", 64'(wd_a), 64'(wd_exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] sl[3];
    int acc;
    int cyc;
    sl = '{32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    vecs[0] = '{64'h1122334455667788, 1'b0, 32'h55667788, 1'b0, 32'h11223344, 1'b1};
    vecs[1] = '{64'h1122334455667788, 1'b1, 32'h11223344, 1'b1, 32'h55667788, 1'b0};
    vecs[2] = '{64'hDEADBEEF01234567, 1'b0, 32'h01234567, 1'b0, 32'hDEADBEEF, 1'b1};
    vecs[3] = '{64'hFFFFFFFF00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0};
    vecs[4] = '{64'hA5A5A5A55A5A5A5A, 1'b1, 32'hA5A5A5A5, 1'b1, 32'h5A5A5A5A, 1'b0};

    bus_a.in_data = '0; bus_a.in_msb = 1'b0; bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
    bus_b.in_data = '0; bus_b.in_msb = 1'b0; bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 64'(bus_a.in_ready), 64'(0));
    check("rst_out_valid", 64'(bus_a.out_valid), 64'(0));
    check("rst_out_data", 64'(bus_a.out_data), 64'(0));
    check("rst_out_idx", 64'(bus_a.out_idx), 64'(0));
    check("rst_out_last", 64'(bus_a.out_last), 64'(0));
    check("rst_busy", 64'(busy_a), 64'(0));
    check("rst_words_done", 64'(wd_a), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_rst_in_ready", 64'(bus_a.in_ready), 64'(1));

    // Table of plain words, both beat orders
    for (int i = 0; i < 5; i++) run_word(vecs[i]);

    // Stall on beat 0 for three cycles
    @(negedge clk);
    bus_a.in_data = vecs[0].word; bus_a.in_msb = 1'b0; bus_a.in_valid = 1'b1;
    bus_a.out_ready = 1'b0;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_data", 64'(bus_a.out_data), 64'(32'h55667788));
      check("stall_idx", 64'(bus_a.out_idx), 64'(0));
      check("stall_in_ready", 64'(bus_a.in_ready), 64'(0));
      @(negedge clk);
    end
    bus_a.out_ready = 1'b1;
    #1 check("stall_release_data", 64'(bus_a.out_data), 64'(32'h55667788));
    @(negedge clk);
    #1;
    check("stall_beat1_data", 64'(bus_a.out_data), 64'(32'h11223344));
    check("stall_beat1_last", 64'(bus_a.out_last), 64'(1));
    wd_exp++;
    @(negedge clk);
    #1 check("stall_words_done", 64'(wd_a), 64'(wd_exp));

    // Two words back to back, no bubble
    @(negedge clk);
    bus_a.in_data = 64'h0123456789ABCDEF; bus_a.in_msb = 1'b0; bus_a.in_valid = 1'b1;
    @(negedge clk);
    bus_a.in_data = 64'hCAFEF00D12345678; bus_a.in_msb = 1'b1;
    #1;
    check("b2b_a0_data", 64'(bus_a.out_data), 64'(32'h89ABCDEF));
    check("b2b_a0_in_ready", 64'(bus_a.in_ready), 64'(0));
    @(negedge clk);
    #1;
    check("b2b_a1_data", 64'(bus_a.out_data), 64'(32'h01234567));
    check("b2b_a1_in_ready", 64'(bus_a.in_ready), 64'(1));
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    #1;
    check("b2b_b0_valid", 64'(bus_a.out_valid), 64'(1));
    check("b2b_b0_data", 64'(bus_a.out_data), 64'(32'hCAFEF00D));
    check("b2b_b0_idx", 64'(bus_a.out_idx), 64'(1));
    @(negedge clk);
    #1;
    check("b2b_b1_data", 64'(bus_a.out_data), 64'(32'h12345678));
    check("b2b_b1_last", 64'(bus_a.out_last), 64'(1));
    wd_exp = wd_exp + 2'd2;
    @(negedge clk);
    #1;
    check("b2b_words_done", 64'(wd_a), 64'(wd_exp));
    check("b2b_idle", 64'(busy_a), 64'(0));

    // Abort in idle blocks acceptance and changes nothing else
    @(negedge clk);
    abort_a = 1'b1; bus_a.in_data = vecs[0].word; bus_a.in_msb = 1'b0; bus_a.in_valid = 1'b1;
    #1 check("abort_idle_in_ready", 64'(bus_a.in_ready), 64'(0));
    @(negedge clk);
    abort_a = 1'b0; bus_a.in_valid = 1'b0;
    #1;
    check("abort_idle_busy", 64'(busy_a), 64'(0));
    check("abort_idle_wd", 64'(wd_a), 64'(wd_exp));

    // Abort after beat 0, consumer stalled: beat 1 never appears
    @(negedge clk);
    bus_a.in_valid = 1'b1;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    #1 check("abort_beat0_valid", 64'(bus_a.out_valid), 64'(1));
    @(negedge clk);
    bus_a.out_ready = 1'b0; abort_a = 1'b1;
    #1 check("abort_in_ready", 64'(bus_a.in_ready), 64'(0));
    @(negedge clk);
    abort_a = 1'b0; bus_a.out_ready = 1'b1;
    #1;
    check("abort_out_valid", 64'(bus_a.out_valid), 64'(0));
    check("abort_busy", 64'(busy_a), 64'(0));
    check("abort_wd", 64'(wd_a), 64'(wd_exp));
    @(negedge clk);
    #1 check("abort_no_beat1", 64'(bus_a.out_valid), 64'(0));

    // Abort while last beat transfers: beat delivered, not counted, no new word taken
    @(negedge clk);
    bus_a.in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    abort_a = 1'b1;
    #1;
    check("abort_last_in_ready", 64'(bus_a.in_ready), 64'(0));
    check("abort_last_beat", 64'(bus_a.out_last), 64'(1));
    @(negedge clk);
    abort_a = 1'b0; bus_a.in_valid = 1'b0;
    #1;
    check("abort_last_busy", 64'(busy_a), 64'(0));
    check("abort_last_wd", 64'(wd_a), 64'(wd_exp));
    run_word(vecs[1]);

    // Three-beat instance, both orders
    for (int m = 0; m < 2; m++) begin
      @(negedge clk);
      bus_b.in_data = 96'hAAAAAAAA_BBBBBBBB_CCCCCCCC; bus_b.in_msb = m[0]; bus_b.in_valid = 1'b1;
      #1 check("w96_in_ready", 64'(bus_b.in_ready), 64'(1));
      @(negedge clk);
      bus_b.in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        int e;
        if (k != 0) @(negedge clk);
        #1;
        e = (m != 0) ? 2 - k : k;
        check("w96_valid", 64'(bus_b.out_valid), 64'(1));
        check("w96_idx", 64'(bus_b.out_idx), 64'(e));
        check("w96_data", 64'(bus_b.out_data), 64'(sl[e]));
        check("w96_last", 64'(bus_b.out_last), 64'(k == 2));
      end
      @(negedge clk);
      #1;
      check("w96_idle", 64'(busy_b), 64'(0));
      check("w96_words_done", 64'(wd_b), 64'(m + 1));
    end

    // 2-bit counter wraps: five words after reset leave words_done at 1
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_a.in_data = vecs[2].word; bus_a.in_msb = 1'b0; bus_a.in_valid = 1'b1;
    bus_a.out_ready = 1'b1;
    acc = 0; cyc = 0;
    while (acc < 5 && cyc < 50) begin
      #1;
      if (bus_a.in_ready) acc++;
      @(negedge clk);
      cyc++;
    end
    bus_a.in_valid = 1'b0;
    check("wrap_accepts", 64'(acc), 64'(5));
    cyc = 0;
    #1;
    while (busy_a && cyc < 20) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("wrap_idle", 64'(busy_a), 64'(0));
    check("wrap_words_done", 64'(wd_a), 64'(1));

    // Reset asserted during beat 1
    @(negedge clk);
    bus_a.in_data = vecs[0].word; bus_a.in_msb = 1'b0; bus_a.in_valid = 1'b1;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    @(negedge clk);
    #1 check("rmid_beat1", 64'(bus_a.out_data), 64'(32'h11223344));
    rst_n = 1'b0;
    #1;
    check("rmid_out_valid", 64'(bus_a.out_valid), 64'(0));
    check("rmid_out_data", 64'(bus_a.out_data), 64'(0));
    check("rmid_words_done", 64'(wd_a), 64'(0));
    check("rmid_in_ready", 64'(bus_a.in_ready), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rmid_rel_in_ready", 64'(bus_a.in_ready), 64'(1));
    check("rmid_rel_busy", 64'(busy_a), 64'(0));
    @(negedge clk);
    #1 check("rmid_no_beats", 64'(bus_a.out_valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
